pipe_stall_ctrl: RTL and testbench

Pipeline sequencer for the 5-stage Otter core. Consumes the hazard unit's load_use_haz/control_haz plus data-memory handshake status. Drives per-stage pipeline-register write enables and flushes, the PC write enable, and a memory-timeout error flag. Sits between HazardUnit and the IF/DE, DE/EX, EX/MEM, MEM/WB registers.

---
 rtl/pipe_stall_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage Otter core.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
//
// state    | meaning
// RUN      | pipeline advancing; resolves load-use / control hazards
// MEM_WAIT | data memory access outstanding; pipeline frozen
module pipe_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load_use_haz,
    input  logic             control_haz,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_de_we,
    output logic             de_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_de_flush,
    output logic             de_ex_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_pend_flush;
    logic              r_mem_err;

    state_t            w_state_nxt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              w_pend_flush_nxt;
    logic              w_mem_err_nxt;
    logic              w_freeze;
    logic              w_ctrl_eff;

    always_comb begin
        w_state_nxt      = r_state;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_pend_flush_nxt = r_pend_flush;
        w_mem_err_nxt    = r_mem_err;
        w_freeze         = 1'b0;
        w_ctrl_eff       = control_haz;

        case (r_state)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    w_freeze         = 1'b1;
                    w_pend_flush_nxt = control_haz;
                    w_wait_cnt_nxt   = WAIT_ONE;
                    w_state_nxt      = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // A timeout is handled exactly like a completion so the pipeline unblocks.
                if (dmem_ready || (r_wait_cnt == WAIT_MAX)) begin
                    w_ctrl_eff       = control_haz | r_pend_flush;
                    w_pend_flush_nxt = 1'b0;
                    w_wait_cnt_nxt   = '0;
                    w_state_nxt      = RUN;
                    if (!dmem_ready) begin
                        w_mem_err_nxt = 1'b1;
                    end
                end else begin
                    w_freeze         = 1'b1;
                    w_pend_flush_nxt = r_pend_flush | control_haz;
                    if (r_wait_cnt != WAIT_MAX) begin
                        w_wait_cnt_nxt = r_wait_cnt + WAIT_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_comb begin
        pc_we       = 1'b1;
        if_de_we    = 1'b1;
        de_ex_we    = 1'b1;
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;
        if_de_flush = 1'b0;
        de_ex_flush = 1'b0;

        if (!RST_N) begin
            pc_we       = 1'b0;
            if_de_we    = 1'b0;
            de_ex_we    = 1'b0;
            ex_mem_we   = 1'b0;
            mem_wb_we   = 1'b0;
            if_de_flush = 1'b1;
            de_ex_flush = 1'b1;
        end else if (w_freeze) begin
            pc_we     = 1'b0;
            if_de_we  = 1'b0;
            de_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
        end else if (w_ctrl_eff) begin
            // Branch is older than the load-use pair, so it wins.
            if_de_flush = 1'b1;
            de_ex_flush = 1'b1;
        end else if (load_use_haz) begin
            pc_we       = 1'b0;
            if_de_we    = 1'b0;
            de_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= RUN;
            r_wait_cnt   <= '0;
            r_pend_flush <= 1'b0;
            r_mem_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_pend_flush <= w_pend_flush_nxt;
            r_mem_err    <= w_mem_err_nxt;
        end
    end

    assign mem_err = r_mem_err;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_we) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (if_de_flush) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a stimulus process pushes expected
// outputs from a rule-level model, a negedge monitor pops and compares them.
module tb_pipe_stall_ctrl;

    localparam int T  = 4;
    localparam int CW = 4;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          load_use_haz = 1'b0;
    logic          control_haz = 1'b0;
    logic          dmem_req = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we;
    logic          if_de_flush, de_ex_flush, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_stall_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .load_use_haz(load_use_haz), .control_haz(control_haz),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .if_de_we(if_de_we), .de_ex_we(de_ex_we),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .if_de_flush(if_de_flush), .de_ex_flush(de_ex_flush),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]    v;   // {pc,if_de,de_ex,ex_mem,mem_wb we, if_de_fl, de_ex_fl, mem_err}
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: plain integers describing the memory-wait episode.
    bit waiting = 0;
    int waited = 0;
    bit branch_owed = 0;
    bit err = 0;
    int stalls = 0;
    int flushes = 0;

    task automatic step(input bit rst_n, input bit lu, input bit ch,
                        input bit req, input bit rdy);
        exp_t e;
        bit   hold, done, br;
        @(posedge CLK);
        #1;
        RST_N = rst_n; load_use_haz = lu; control_haz = ch;
        dmem_req = req; dmem_ready = rdy;
        e.sc = PERF ? CW'(stalls) : '0;
        e.fc = PERF ? CW'(flushes) : '0;
        if (!rst_n) begin
            e.v = {5'b00000, 2'b11, err};
            waiting = 0; waited = 0; branch_owed = 0; err = 0;
            stalls = 0; flushes = 0;
        end else begin
            done = waiting && (rdy || waited >= T);
            hold = waiting ? !done : (req && !rdy);
            br   = ch || (done && branch_owed);
            if (hold)
                e.v = {5'b00000, 2'b00, err};
            else if (br)
                e.v = {5'b11111, 2'b11, err};
            else if (lu)
                e.v = {5'b00111, 2'b01, err};
            else
                e.v = {5'b11111, 2'b00, err};
            if (!e.v[7]) stalls = (stalls + 1) % 16;
            if (e.v[2]) flushes = (flushes + 1) % 16;
            if (done) begin
                if (!rdy) err = 1;
                waiting = 0; branch_owed = 0; waited = 0;
            end else if (waiting) begin
                branch_owed = branch_owed || ch;
                waited = waited + 1;
            end else if (hold) begin
                waiting = 1; waited = 1; branch_owed = ch;
            end
        end
        q.push_back(e);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        logic [7:0] got;
        if (q.size() > 0) begin
            e = q.pop_front();
            got = {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we,
                   if_de_flush, de_ex_flush, mem_err};
            n_total++;
            if (got !== e.v) $display("FAIL ctl_vec t=%0t got=%b exp=%b", $time, got, e.v);
            else n_pass++;
            n_total++;
            if (stall_cnt !== e.sc) $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, e.sc);
            else n_pass++;
            n_total++;
            if (flush_cnt !== e.fc) $display("FAIL flush_cnt t=%0t got=%0d exp=%0d", $time, flush_cnt, e.fc);
            else n_pass++;
        end
    end

    initial begin
        // reset, then load-use, simultaneous hazards
        step(0,0,0,0,0); step(0,0,0,0,0);
        step(1,0,0,0,0); step(1,1,0,0,0); step(1,0,0,0,0);
        step(0,0,0,0,0); step(1,1,1,0,0); step(1,0,0,0,0);
        // memory wait with a branch arriving mid-wait
        step(0,0,0,0,0);
        step(1,0,0,1,0); step(1,0,1,1,0); step(1,0,0,1,0); step(1,0,0,1,1);
        step(1,0,0,0,0);
        // ready without request is ignored
        step(1,0,0,0,1);
        // timeout: mem_err sticky afterwards
        step(1,0,0,1,0);
        for (int i = 0; i < 5; i++) step(1,0,0,1,0);
        step(1,0,0,0,0); step(1,1,0,0,0); step(1,0,0,0,0);
        // counter wrap: 17 load-use stalls
        step(0,0,0,0,0);
        for (int i = 0; i < 17; i++) begin
            step(1,1,0,0,0); step(1,0,0,0,0);
        end
        // reset in the middle of a wait with a pending branch
        step(1,0,1,1,0); step(1,0,0,1,0); step(0,0,0,1,0); step(1,0,0,0,0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0,199) != 0),
                 ($urandom_range(0,3) == 0),
                 ($urandom_range(0,5) == 0),
                 ($urandom_range(0,2) == 0),
                 ($urandom_range(0,2) == 0));
        end
        repeat (3) @(posedge CLK);
        n_total++;
        if (q.size() != 0) $display("FAIL queue_drain got=%0d exp=0", q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
